// File: rtl/axi4_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_responder_if
// Brief    : AXI4 bus bundle (AW/W/B/AR/R) for the memory responder.
// Revision : 1.0
// ============================================================================
interface axi4_mem_responder_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 12
);
   logic [ID_W-1:0]   s_axi_awid;
   logic [ADDR_W-1:0] s_axi_awaddr;
   logic [7:0]        s_axi_awlen;
   logic [2:0]        s_axi_awsize;
   logic [1:0]        s_axi_awburst;
   logic              s_axi_awvalid;
   logic              s_axi_awready;

   logic [31:0]       s_axi_wdata;
   logic [3:0]        s_axi_wstrb;
   logic              s_axi_wlast;
   logic              s_axi_wvalid;
   logic              s_axi_wready;

   logic [ID_W-1:0]   s_axi_bid;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid;
   logic              s_axi_bready;

   logic [ID_W-1:0]   s_axi_arid;
   logic [ADDR_W-1:0] s_axi_araddr;
   logic [7:0]        s_axi_arlen;
   logic [2:0]        s_axi_arsize;
   logic [1:0]        s_axi_arburst;
   logic              s_axi_arvalid;
   logic              s_axi_arready;

   logic [ID_W-1:0]   s_axi_rid;
   logic [31:0]       s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rlast;
   logic              s_axi_rvalid;
   logic              s_axi_rready;

   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready
   );

   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bid, s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready
   );
endinterface
`default_nettype wire

// File: rtl/axi4_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_responder
// Brief    : AXI4 slave with one write and one read burst in flight over a
//            32-bit word memory; INCR/FIXED/WRAP bursts, SLVERR on errors.
// Revision : 1.0
// ============================================================================
module axi4_mem_responder #(
   parameter int ADDR_W    = 12,
   parameter int ID_W      = 4,
   parameter int MEM_BYTES = 1024
) (
   input  wire logic           aclk,
   input  wire logic           areset,
   axi4_mem_responder_if.slave s_axi
);
   localparam int MEM_WORDS = MEM_BYTES / 4;
   localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [7:0] len,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] sum;
      logic [ADDR_W-1:0] wrap_mask;
      step      = ADDR_W'(1) << size;
      sum       = addr + step;
      // Legal wrap lengths make the window a power of two, so the wrap is a mask merge.
      wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         2'b01:   next_addr = sum;
         2'b10:   next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
         default: next_addr = addr;
      endcase
   endfunction

   function automatic logic burst_illegal(input logic [7:0] len, input logic [2:0] size,
                                          input logic [1:0] burst);
      burst_illegal = (size > 3'd2) || (burst == 2'b11) ||
                      ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                             (len == 8'd7) || (len == 8'd15)));
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      in_range = ({1'b0, addr} < MEM_LIMIT);
   endfunction

   function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      word_idx = addr[MEM_AW+1:2];
   endfunction

   logic [31:0] mem [0:MEM_WORDS-1];

   // ---------------- write channel ----------------
   logic [1:0]        w_state_q, w_state_d;
   logic [ID_W-1:0]   w_id_q, w_id_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [7:0]        w_len_q, w_len_d;
   logic [2:0]        w_size_q, w_size_d;
   logic [1:0]        w_burst_q, w_burst_d;
   logic [7:0]        w_cnt_q, w_cnt_d;
   logic              w_err_q, w_err_d;
   logic              w_bad_q, w_bad_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              w_last_beat, w_beat_err;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_widx;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         w_bad_q   <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         w_bad_q   <= w_bad_d;
         bresp_q   <= bresp_d;
      end
   end

   always_comb begin
      w_state_d   = w_state_q;
      w_id_d      = w_id_q;
      w_addr_d    = w_addr_q;
      w_len_d     = w_len_q;
      w_size_d    = w_size_q;
      w_burst_d   = w_burst_q;
      w_cnt_d     = w_cnt_q;
      w_err_d     = w_err_q;
      w_bad_d     = w_bad_q;
      bresp_d     = bresp_q;
      mem_we      = 1'b0;
      mem_widx    = word_idx(w_addr_q);
      w_last_beat = (w_cnt_q == w_len_q);
      w_beat_err  = !in_range(w_addr_q) || w_bad_q || (s_axi.s_axi_wlast != w_last_beat);
      case (w_state_q)
         W_IDLE: begin
            if (s_axi.s_axi_awvalid) begin
               w_id_d    = s_axi.s_axi_awid;
               w_addr_d  = s_axi.s_axi_awaddr;
               w_len_d   = s_axi.s_axi_awlen;
               w_size_d  = s_axi.s_axi_awsize;
               w_burst_d = s_axi.s_axi_awburst;
               w_bad_d   = burst_illegal(s_axi.s_axi_awlen, s_axi.s_axi_awsize, s_axi.s_axi_awburst);
               w_cnt_d   = '0;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi.s_axi_wvalid) begin
               mem_we   = !w_bad_q && in_range(w_addr_q);
               w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
               w_cnt_d  = w_cnt_q + 8'd1;
               w_err_d  = w_err_q | w_beat_err;
               // Termination follows the beat count; a wrong wlast only flags the response.
               if (w_last_beat) begin
                  bresp_d   = (w_err_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (s_axi.s_axi_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      s_axi.s_axi_awready = (w_state_q == W_IDLE);
      s_axi.s_axi_wready  = (w_state_q == W_DATA);
      s_axi.s_axi_bvalid  = (w_state_q == W_RESP);
      s_axi.s_axi_bid     = w_id_q;
      s_axi.s_axi_bresp   = bresp_q;
   end

   // Memory has no reset so its contents survive areset.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (s_axi.s_axi_wstrb[b]) mem[mem_widx][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   logic [0:0]        r_state_q, r_state_d;
   logic [ID_W-1:0]   r_id_q, r_id_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [7:0]        r_len_q, r_len_d;
   logic [2:0]        r_size_q, r_size_d;
   logic [1:0]        r_burst_q, r_burst_d;
   logic [7:0]        r_cnt_q, r_cnt_d;
   logic              r_bad_q, r_bad_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rlast_q, rlast_d;
   logic [ADDR_W-1:0] r_fetch_addr;
   logic              r_fetch_ok;
   logic [31:0]       r_fetch_data;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_cnt_q   <= '0;
         r_bad_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rlast_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_cnt_q   <= r_cnt_d;
         r_bad_q   <= r_bad_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   always_comb begin
      r_state_d    = r_state_q;
      r_id_d       = r_id_q;
      r_addr_d     = r_addr_q;
      r_len_d      = r_len_q;
      r_size_d     = r_size_q;
      r_burst_d    = r_burst_q;
      r_cnt_d      = r_cnt_q;
      r_bad_d      = r_bad_q;
      rdata_d      = rdata_q;
      rresp_d      = rresp_q;
      rlast_d      = rlast_q;
      // r_addr_q always holds the address of the next beat to capture.
      r_fetch_addr = (r_state_q == R_IDLE) ? s_axi.s_axi_araddr : r_addr_q;
      r_fetch_ok   = in_range(r_fetch_addr) &&
                     ((r_state_q == R_IDLE) ?
                      !burst_illegal(s_axi.s_axi_arlen, s_axi.s_axi_arsize, s_axi.s_axi_arburst) :
                      !r_bad_q);
      r_fetch_data = r_fetch_ok ? mem[word_idx(r_fetch_addr)] : 32'd0;
      case (r_state_q)
         R_IDLE: begin
            if (s_axi.s_axi_arvalid) begin
               r_id_d    = s_axi.s_axi_arid;
               r_len_d   = s_axi.s_axi_arlen;
               r_size_d  = s_axi.s_axi_arsize;
               r_burst_d = s_axi.s_axi_arburst;
               r_bad_d   = burst_illegal(s_axi.s_axi_arlen, s_axi.s_axi_arsize, s_axi.s_axi_arburst);
               r_addr_d  = next_addr(s_axi.s_axi_araddr, s_axi.s_axi_arlen,
                                     s_axi.s_axi_arsize, s_axi.s_axi_arburst);
               r_cnt_d   = '0;
               rdata_d   = r_fetch_data;
               rresp_d   = r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
               rlast_d   = (s_axi.s_axi_arlen == 8'd0);
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_axi.s_axi_rready) begin
               if (rlast_q) begin
                  rlast_d   = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d  = r_cnt_q + 8'd1;
                  r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                  rdata_d  = r_fetch_data;
                  rresp_d  = r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
                  rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      s_axi.s_axi_arready = (r_state_q == R_IDLE);
      s_axi.s_axi_rvalid  = (r_state_q == R_DATA);
      s_axi.s_axi_rid     = r_id_q;
      s_axi.s_axi_rdata   = rdata_q;
      s_axi.s_axi_rresp   = rresp_q;
      s_axi.s_axi_rlast   = rlast_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mem_responder
// Brief    : Directed + randomized bench for axi4_mem_responder against a
//            byte-level burst model of the memory.
// Revision : 1.0
// ============================================================================
module tb_axi4_mem_responder;
   localparam int ID_W      = 4;
   localparam int ADDR_W    = 12;
   localparam int MEM_BYTES = 1024;

   logic aclk   = 1'b0;
   logic areset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] mdl [0:MEM_BYTES/4-1];
   logic [31:0] wd  [0:255];
   logic [3:0]  ws  [0:255];

   axi4_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

   axi4_mem_responder #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_BYTES(MEM_BYTES)) dut (
      .aclk   (aclk),
      .areset (areset),
      .s_axi  (bus.slave)
   );

   always #5 aclk = ~aclk;

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit illegal_b(input int len, input int size, input int burst);
      return (size > 2) || (burst == 3) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // Byte address of beat i, straight from the burst rules.
   function automatic int beat_addr(input int start, input int len, input int size,
                                    input int burst, input int i);
      int incr, wb, base;
      incr = 1 << size;
      case (burst)
         1: return (start + i*incr) & 'hFFF;
         2: begin
            wb   = (len + 1) * incr;
            base = (start / wb) * wb;
            return base + ((start - base + i*incr) % wb);
         end
         default: return start;
      endcase
   endfunction

   task automatic do_write(input int id, input int addr, input int len, input int size,
                           input int burst, input int bad_last, input bit stall);
      bit err, bad;
      int a, n;
      logic [31:0] w;
      bad = illegal_b(len, size, burst);
      err = bad;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, len, size, burst, i);
         if (a >= MEM_BYTES) err = 1'b1;
         else if (!bad) begin
            w = mdl[a >> 2];
            for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
            mdl[a >> 2] = w;
         end
         if (i == bad_last) err = 1'b1;
      end
      @(negedge aclk);
      bus.s_axi_awid    = 4'(id);
      bus.s_axi_awaddr  = 12'(addr);
      bus.s_axi_awlen   = 8'(len);
      bus.s_axi_awsize  = 3'(size);
      bus.s_axi_awburst = 2'(burst);
      bus.s_axi_awvalid = 1'b1;
      check("awready", 32'(bus.s_axi_awready), 32'd1);
      n = 0;
      while (!bus.s_axi_awready && n < 100) begin @(negedge aclk); n++; end
      @(negedge aclk);
      bus.s_axi_awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         bus.s_axi_wvalid = 1'b1;
         bus.s_axi_wdata  = wd[i];
         bus.s_axi_wstrb  = ws[i];
         bus.s_axi_wlast  = (i == len) != (i == bad_last);
         check("wready", 32'(bus.s_axi_wready), 32'd1);
         n = 0;
         while (!bus.s_axi_wready && n < 100) begin @(negedge aclk); n++; end
         @(negedge aclk);
      end
      bus.s_axi_wvalid = 1'b0;
      bus.s_axi_wlast  = 1'b0;
      check("bvalid_rise", 32'(bus.s_axi_bvalid), 32'd1);
      n = 0;
      while (n < 100) begin
         bus.s_axi_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         check("bvalid_hold", 32'(bus.s_axi_bvalid), 32'd1);
         if (bus.s_axi_bready) begin
            check("bid", 32'(bus.s_axi_bid), 32'(id & 15));
            check("bresp", 32'(bus.s_axi_bresp), err ? 32'd2 : 32'd0);
            break;
         end
         @(negedge aclk);
         n++;
      end
      @(negedge aclk);
      bus.s_axi_bready = 1'b0;
      check("bvalid_fall", 32'(bus.s_axi_bvalid), 32'd0);
      check("aw_turnaround", 32'(bus.s_axi_awready), 32'd1);
   endtask

   task automatic do_read(input int id, input int addr, input int len, input int size,
                          input int burst, input bit stall);
      bit bad;
      int a, i, n;
      logic [31:0] ed;
      logic [1:0]  er;
      bad = illegal_b(len, size, burst);
      @(negedge aclk);
      bus.s_axi_arid    = 4'(id);
      bus.s_axi_araddr  = 12'(addr);
      bus.s_axi_arlen   = 8'(len);
      bus.s_axi_arsize  = 3'(size);
      bus.s_axi_arburst = 2'(burst);
      bus.s_axi_arvalid = 1'b1;
      check("arready", 32'(bus.s_axi_arready), 32'd1);
      n = 0;
      while (!bus.s_axi_arready && n < 100) begin @(negedge aclk); n++; end
      @(negedge aclk);
      bus.s_axi_arvalid = 1'b0;
      i = 0;
      n = 0;
      while (i <= len && n < 2000) begin
         a = beat_addr(addr, len, size, burst, i);
         if (bad || a >= MEM_BYTES) begin ed = 32'd0; er = 2'b10; end
         else begin ed = mdl[a >> 2]; er = 2'b00; end
         check("rvalid", 32'(bus.s_axi_rvalid), 32'd1);
         check("rdata", bus.s_axi_rdata, ed);
         check("rresp", 32'(bus.s_axi_rresp), 32'(er));
         check("rlast", 32'(bus.s_axi_rlast), 32'(i == len));
         check("rid", 32'(bus.s_axi_rid), 32'(id & 15));
         bus.s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge aclk);
         if (bus.s_axi_rready) i++;
         n++;
      end
      bus.s_axi_rready = 1'b0;
      check("rvalid_fall", 32'(bus.s_axi_rvalid), 32'd0);
      check("arready_back", 32'(bus.s_axi_arready), 32'd1);
   endtask

   task automatic pick_burst(output int sz, output int bu, output int ln, input bit allow_bad);
      sz = int'($urandom_range(0, 2));
      bu = int'($urandom_range(0, 2));
      case (bu)
         0:       ln = int'($urandom_range(0, 7));
         1:       ln = int'($urandom_range(0, 15));
         default: ln = (2 << $urandom_range(0, 3)) - 1;
      endcase
      if (allow_bad && $urandom_range(0, 7) == 0) begin
         case ($urandom_range(0, 2))
            0:       sz = 3;
            1:       bu = 3;
            default: begin bu = 2; ln = 2; end
         endcase
      end
   endtask

   initial begin
      int sz, bu, ln, ad, sz2, bu2, ln2, ad2, bl;
      bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
      bus.s_axi_awsize = '0; bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
      bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b0;

      // Reset values
      repeat (3) @(negedge aclk);
      check("rst_awready", 32'(bus.s_axi_awready), 32'd1);
      check("rst_arready", 32'(bus.s_axi_arready), 32'd1);
      check("rst_wready",  32'(bus.s_axi_wready),  32'd0);
      check("rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
      check("rst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
      check("rst_rlast",   32'(bus.s_axi_rlast),   32'd0);
      check("rst_bid",     32'(bus.s_axi_bid),     32'd0);
      check("rst_bresp",   32'(bus.s_axi_bresp),   32'd0);
      check("rst_rid",     32'(bus.s_axi_rid),     32'd0);
      check("rst_rdata",   bus.s_axi_rdata,        32'd0);
      check("rst_rresp",   32'(bus.s_axi_rresp),   32'd0);
      areset = 1'b0;

      // Fill the whole memory so the model starts from known contents.
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(0, 0, 255, 2, 1, -1, 1'b0);

      // INCR write then back-to-back INCR read
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      do_write(1, 'h010, 3, 2, 1, -1, 1'b0);
      do_read(2, 'h010, 3, 2, 1, 1'b0);

      // WRAP read, then illegal WRAP length
      do_read(3, 'h018, 3, 2, 2, 1'b0);
      do_read(4, 'h018, 2, 2, 2, 1'b0);

      // Strobes
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
      do_write(5, 'h040, 0, 2, 1, -1, 1'b0);
      wd[0] = 32'h1234_5678; ws[0] = 4'h5;
      do_write(6, 'h040, 0, 2, 1, -1, 1'b0);
      do_read(7, 'h040, 0, 2, 1, 1'b0);

      // Range error on second beat, wlast protocol error, illegal burst type
      wd[0] = 32'h1111_2222; wd[1] = 32'h3333_4444; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(8, MEM_BYTES - 4, 1, 2, 1, -1, 1'b0);
      do_read(9, MEM_BYTES - 4, 1, 2, 1, 1'b0);
      wd[0] = 32'h5555_6666; wd[1] = 32'h7777_8888;
      do_write(10, 'h080, 1, 2, 1, 0, 1'b0);
      do_read(11, 'h080, 1, 2, 1, 1'b0);
      do_write(12, 'h0C0, 1, 2, 3, -1, 1'b0);
      do_read(13, 'h0C0, 1, 2, 1, 1'b0);

      // Reset mid-write: first beat lands, no response afterwards
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      @(negedge aclk);
      bus.s_axi_awid = 4'd5; bus.s_axi_awaddr = 12'h300; bus.s_axi_awlen = 8'd3;
      bus.s_axi_awsize = 3'd2; bus.s_axi_awburst = 2'd1; bus.s_axi_awvalid = 1'b1;
      @(negedge aclk);
      bus.s_axi_awvalid = 1'b0;
      check("mid_wready", 32'(bus.s_axi_wready), 32'd1);
      bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = wd[0]; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1'b0;
      @(negedge aclk);
      bus.s_axi_wvalid = 1'b0;
      mdl['h300 >> 2] = wd[0];
      areset = 1'b1;
      #1;
      check("mid_rst_awready", 32'(bus.s_axi_awready), 32'd1);
      check("mid_rst_wready",  32'(bus.s_axi_wready),  32'd0);
      check("mid_rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
      @(negedge aclk);
      areset = 1'b0;
      repeat (4) begin
         @(negedge aclk);
         check("post_rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
         check("post_rst_awready", 32'(bus.s_axi_awready), 32'd1);
      end
      do_read(6, 'h300, 0, 2, 1, 1'b0);

      // Random sequential bursts with stalls
      for (int t = 0; t < 24; t++) begin
         pick_burst(sz, bu, ln, 1'b1);
         ad = int'($urandom_range(0, 'h4FF)) & ~((1 << sz) - 1);
         for (int i = 0; i <= ln; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
         bl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ln)) : -1;
         do_write(int'($urandom_range(0, 15)), ad, ln, sz, bu, bl, 1'b1);
         do_read(int'($urandom_range(0, 15)), ad, ln, sz, bu, 1'b1);
      end

      // Overlapping read and write bursts on disjoint regions
      for (int t = 0; t < 10; t++) begin
         pick_burst(sz, bu, ln, 1'b0);
         ad = int'($urandom_range(0, 'h17F)) & ~((1 << sz) - 1);
         pick_burst(sz2, bu2, ln2, 1'b0);
         ad2 = int'($urandom_range('h200, 'h37F)) & ~((1 << sz2) - 1);
         for (int i = 0; i <= ln; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
         fork
            do_write(int'($urandom_range(0, 15)), ad, ln, sz, bu, -1, 1'b1);
            do_read(int'($urandom_range(0, 15)), ad2, ln2, sz2, bu2, 1'b1);
         join
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

Synthesizable AXI4 slave responder with a single-port on-chip word memory. It is the target end of the AXI4 links driven by the master-side stimulus. It also stands in for the slave VIP, so the scoreboards can compare master-side monitor traffic against real RTL responses. One write burst and one read burst may be in flight at a time, on independent channels, with INCR, FIXED and WRAP bursts.

## Interface
- ADDR_W, 12, byte-address width of AW/AR.
- ID_W, 4, width of all ID fields.
- MEM_BYTES, 1024, memory size in bytes. Must be a multiple of 4 and ≤ 2^ADDR_W.
- Data width is fixed at 32 bits (4 strobe bits).

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address fields.
- s_axi_awvalid in 1, s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast  in  32/4/1  write data fields.
- s_axi_wvalid in 1, s_axi_wready out 1  W handshake.
- s_axi_bid/bresp  out  ID_W/2  write response fields.
- s_axi_bvalid out 1, s_axi_bready in 1  B handshake.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address fields.
- s_axi_arvalid in 1, s_axi_arready out 1  AR handshake.
- s_axi_rid/rdata/rresp/rlast  out  ID_W/32/2/1  read data fields.
- s_axi_rvalid out 1, s_axi_rready in 1  R handshake.

## Operation
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, clear beat count and error flag, go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write the wstrb-enabled bytes to word addr[ADDR_W-1:2], then advance the address and count.
  - When count==len on a handshake, go to W_RESP.
  - W_RESP: bvalid=1 and bid=latched id. Hold until bready, then go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch fields and capture beat 0 into the rdata register, then go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(count==len).
  - On each R handshake that is not the last beat, capture the next beat into rdata. After the last beat, go to R_IDLE.
- Address advance per beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: increment, and when the wrap boundary is crossed, return to the aligned base. The boundary is (len+1)<<size and the base is addr aligned down to that boundary.
- Error rules:
  - A beat with address ≥ MEM_BYTES is out of range. A write beat is not stored; a read beat returns rdata=0 with rresp=SLVERR(2'b10). In-range read beats return OKAY.
  - A burst is illegal when size>2, burst==2'b11, or it is WRAP with len not in {1,3,7,15}. An illegal burst still completes its full len+1 beats but makes no memory access.
  - Every read beat of an illegal burst returns SLVERR and rdata=0.
  - bresp=SLVERR if any write beat was out of range, the burst was illegal, or wlast≠(count==len) on any beat. Otherwise bresp=OKAY.
  - A burst always ends on count==len, regardless of wlast.
- Narrow sizes (<2): the memory access is still word-indexed. A write honors wstrb as given; a read returns the full word.
- Memory is never reset. Its contents survive areset.

## Timing
- Reset values: awready=1, arready=1. wready, bvalid, rvalid and rlast are 0. bid, bresp, rid, rdata and rresp are 0. Both FSMs go to IDLE.
- AW handshake at edge N → wready=1 from cycle N+1. W beats are accepted back-to-back at one per cycle.
- Last W handshake at edge M → bvalid=1 from cycle M+1. The write B→AW turnaround is 1 cycle, with awready=1 only in W_IDLE.
- AR handshake at edge N → rvalid=1 with beat 0 valid from cycle N+1. With rready held high, one beat per cycle and no bubbles.
- rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
- Read/write collision on the same word: the rdata register captures memory as of before that edge's write. A later write does not alter a beat that has already been captured.
- areset asserted mid-burst: outputs immediately take their reset values and the burst is abandoned. Any beats already written remain in memory.

## Test plan
- INCR write: awaddr=0x010, awlen=3, size=2, data 0xA0..0xA3, wstrb=0xF → bresp=OKAY. INCR read of the same 4 beats → 0xA0..0xA3 with rlast on beat 3, back-to-back.
- WRAP read: araddr=0x018, arlen=3, size=2 → beat addresses 0x018, 0x01C, 0x010, 0x014. An illegal WRAP with arlen=2 → 3 beats, all SLVERR, rdata=0.
- Strobes: write 0xFFFFFFFF to 0x040, then write 0x12345678 with wstrb=0x5 → a read of 0x040 returns 0xFF34FF78.
- Range and protocol errors: awaddr=MEM_BYTES-4, awlen=1 → second beat dropped, bresp=SLVERR. A write with wlast=1 on beat 0 of awlen=1 → bresp=SLVERR.
- Backpressure and concurrency: random rready/bready stalls with overlapping read and write bursts → rdata stable while stalled and IDs echoed. areset mid-write → bvalid never asserts, and awready=1 from the next cycle.
